// File: rtl/bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 8-bit CPU data bus.
// Four requesters compete for the bus. One owner holds it at a time, and a
// one-cycle RELEASE gap separates consecutive owners so the negedge-registered
// data mux never sees two drivers.
module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] rw_req,
  output logic [3:0] gnt,
  output logic [2:0] data_sel,
  output logic       rw_sel,
  output logic       bus_busy
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [1:0]        owner_reg, owner_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0]        gnt_next;
  logic [2:0]        data_sel_next;
  logic              rw_sel_next;

  logic [1:0] cand [4];
  logic [3:0] cand_req;
  logic [1:0] winner;
  logic       any_req;
  logic       other_req;

  // Candidate k is owner+1+k (mod 4), so the current owner is scanned last.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scan
      assign cand[gi]     = owner_reg + 2'(gi + 1);
      assign cand_req[gi] = req[cand[gi]];
    end
  endgenerate

  assign any_req   = |req;
  assign other_req = |(req & ~(4'b0001 << owner_reg));

  // Pick the first requesting candidate in round-robin order.
  always_comb begin
    winner = cand[3];
    for (int k = 3; k >= 0; k--) begin
      if (cand_req[k]) winner = cand[k];
    end
  end

  // Next-state and next-output decode; outputs default to the open-bus source.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    hold_cnt_next = '0;
    gnt_next      = 4'b0000;
    data_sel_next = 3'b111;
    rw_sel_next   = 1'b1;
    case (state_reg)
      ST_GRANT: begin
        if (!req[owner_reg] || (hold_cnt_reg == HOLD_LAST && other_req)) begin
          state_next = ST_RELEASE;
        end else begin
          // Hold count saturates so a lone owner keeps the bus indefinitely.
          hold_cnt_next = (hold_cnt_reg == HOLD_LAST) ? hold_cnt_reg
                                                      : hold_cnt_reg + 1'b1;
          gnt_next      = 4'b0001 << owner_reg;
          data_sel_next = {1'b0, owner_reg};
          rw_sel_next   = rw_req[owner_reg];
        end
      end
      default: begin
        // IDLE and RELEASE both grant straight away when anyone is waiting.
        if (any_req) begin
          state_next    = ST_GRANT;
          owner_next    = winner;
          gnt_next      = 4'b0001 << winner;
          data_sel_next = {1'b0, winner};
          rw_sel_next   = rw_req[winner];
        end else begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; reset drops the grant without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= 2'd3;
      hold_cnt_reg <= '0;
      gnt          <= 4'b0000;
      data_sel     <= 3'b111;
      rw_sel       <= 1'b1;
      bus_busy     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      hold_cnt_reg <= hold_cnt_next;
      gnt          <= gnt_next;
      data_sel     <= data_sel_next;
      rw_sel       <= rw_sel_next;
      bus_busy     <= (state_next == ST_GRANT);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed steps followed by random
// traffic, all compared against a behavioural ownership model.
module tb_bus_arbiter;

  localparam int MAX_HOLD   = 16;
  localparam int WAIT_BOUND = 3 * (MAX_HOLD + 1) + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] rw_req = 4'b0000;
  logic [3:0] gnt;
  logic [2:0] data_sel;
  logic       rw_sel;
  logic       bus_busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: who owns the bus and for how many cycles so far.
  bit m_granted;
  int m_owner;
  int m_held;
  bit m_rw;

  int wait_cnt [4];
  int max_wait;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .rw_req   (rw_req),
    .gnt      (gnt),
    .data_sel (data_sel),
    .rw_sel   (rw_sel),
    .bus_busy (bus_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int own, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(own + k) % 4]) return (own + k) % 4;
    end
    return own;
  endfunction

  task automatic model_reset();
    m_granted = 1'b0;
    m_owner   = 3;
    m_held    = 0;
    m_rw      = 1'b1;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  // Ownership rules applied once per rising edge to the sampled inputs.
  task automatic model_step(input logic [3:0] r, input logic [3:0] rw);
    logic [3:0] others;
    if (m_granted) begin
      others = r & ~(4'b0001 << m_owner);
      if (!r[m_owner] || (m_held >= MAX_HOLD && others != 4'b0000)) begin
        m_granted = 1'b0;
      end else begin
        m_held++;
        m_rw = rw[m_owner];
      end
    end else if (r != 4'b0000) begin
      m_owner   = pick(m_owner, r);
      m_granted = 1'b1;
      m_held    = 1;
      m_rw      = rw[m_owner];
    end
  endtask

  task automatic check_model();
    logic [3:0] e_gnt;
    logic [2:0] e_sel;
    e_gnt = m_granted ? (4'b0001 << m_owner) : 4'b0000;
    e_sel = m_granted ? {1'b0, 2'(m_owner)} : 3'b111;
    chk("model_gnt", gnt, e_gnt);
    chk("model_data_sel", data_sel, e_sel);
    chk("model_rw_sel", rw_sel, m_granted ? m_rw : 1'b1);
    chk("model_busy", bus_busy, m_granted);
    chk("onehot0_gnt", $onehot0(gnt), 1);
    chk("sel_vs_gnt", data_sel[2], gnt == 4'b0000);
    for (int i = 0; i < 4; i++) begin
      if (req[i] && !gnt[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(req, rw_req);
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] r;
    logic b;
    max_wait = 0;
    model_reset();

    // Reset values with random requests present.
    r = $urandom;
    req = r[3:0];
    rw_req = r[7:4];
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_data_sel", data_sel, 3'b111);
    chk("rst_rw_sel", rw_sel, 1'b1);
    chk("rst_busy", bus_busy, 1'b0);

    // Leave reset with everyone requesting: requester 0 wins first.
    req = 4'b1111;
    reset = 1'b0;
    model_reset();
    tick();
    chk("first_after_rst", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    tick();

    // Single request from IDLE with a write intent.
    req = 4'b0100;
    rw_req = 4'b1011;
    tick();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_sel", data_sel, 3'b010);
    chk("single_rw", rw_sel, 1'b0);
    req = 4'b0000;
    tick();
    chk("single_drop", gnt, 4'b0000);
    tick();
    chk("single_idle_busy", bus_busy, 1'b0);

    // Round-robin between 0 and 1, each holding exactly MAX_HOLD cycles.
    req = 4'b0011;
    for (int k = 0; k < MAX_HOLD; k++) begin
      tick();
      chk("rr_own0", gnt, 4'b0001);
    end
    tick();
    chk("rr_gap0", gnt, 4'b0000);
    for (int k = 0; k < MAX_HOLD; k++) begin
      tick();
      chk("rr_own1", gnt, 4'b0010);
    end
    tick();
    chk("rr_gap1", gnt, 4'b0000);
    tick();
    chk("rr_back0", gnt, 4'b0001);

    // Lone owner 3 keeps the bus well past MAX_HOLD.
    req = 4'b1000;
    tick();
    chk("pre_gap", gnt, 4'b0000);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("lone_hold", gnt, 4'b1000);
    end
    // A saturated owner is preempted at the next edge.
    req = 4'b1010;
    tick();
    chk("preempt_drop", gnt, 4'b0000);
    tick();
    chk("preempt_new", gnt, 4'b0010);

    // rw_sel tracks rw_req[1] one cycle late; other bits are ignored.
    req = 4'b0010;
    b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      r = $urandom;
      rw_req = r[3:0];
      rw_req[1] = b;
      tick();
      chk("rw_follow", rw_sel, b);
      chk("rw_gnt", gnt, 4'b0010);
      b = ~b;
    end

    // Reset between edges while 3 owns the bus.
    req = 4'b1000;
    tick();
    tick();
    chk("midrst_pre", gnt, 4'b1000);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_gnt", gnt, 4'b0000);
    chk("midrst_sel", data_sel, 3'b111);
    chk("midrst_rw", rw_sel, 1'b1);
    chk("midrst_busy", bus_busy, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req = 4'b1001;
    tick();
    chk("midrst_owner0", gnt, 4'b0001);

    // Random traffic with long-lived requests so preemption happens.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(31) == 0) req[i] = ~req[i];
      end
      r = $urandom;
      rw_req = r[3:0];
      tick();
    end
    chk("max_wait_bound", max_wait <= WAIT_BOUND, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
